// File: rtl/gx4000_sprite_linebuf.sv
// GX4000 Plus sprite line buffer: fetches 16 sprites per line into a ping-pong pair of line buffers.
// Optional feature: define GX4000_SPRITE_COLLIDE_EN to enable sticky sprite collision flags.
module gx4000_sprite_linebuf #(
  parameter int          LINE_W    = 384,
  parameter logic [13:0] PAT_BASE  = 14'h0000,
  parameter logic [13:0] ATTR_BASE = 14'h2000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        plus_mode,
  input  logic        line_start,
  input  logic [8:0]  next_vpos,
  input  logic [8:0]  hpos,
  input  logic        pix_ce,
  output logic [13:0] asic_ram_addr,
  output logic        asic_ram_rd,
  input  logic [7:0]  asic_ram_q,
  output logic        spr_valid,
  output logic [3:0]  spr_pen,
  output logic [3:0]  spr_id,
  output logic        busy,
  output logic        overrun,
  input  logic        coll_clr,
  output logic [15:0] collision_flags
);

  localparam int         AW = $clog2(LINE_W);
  localparam logic [9:0] LW = 10'(LINE_W);

  typedef enum logic [2:0] {S_IDLE, S_ATTR, S_CHECK, S_PAT, S_NEXT} state_e;

  state_e              state_q, state_d;
  logic [3:0]          idx_q;
  logic [4:0]          cnt_q;
  logic                dv_q;
  logic [3:0]          dtag_q;
  logic [7:0]          xlo_q, ylo_q;
  logic                xhi_q, yhi_q;
  logic [3:0]          mag_q;
  logic [3:0]          row_q;
  logic [8:0]          vpos_q;
  logic                sel_q;
  logic                overrun_q;
  logic [1:0][LINE_W-1:0] vld_q;
  logic [7:0]          ent_q [2][LINE_W];
  logic                spr_valid_q;
  logic [3:0]          spr_pen_q, spr_id_q;

  logic [1:0] shx, shy;
  logic [9:0] xpos, ypos, vpos10, ylast, ydiff, hpos10;
  logic       hit;
  logic [2:0] sx;
  logic [3:0] pen_in;
  logic [9:0] wcol [4];
  logic [3:0] wen;
  logic [AW-1:0] hidx;
  logic       rd_en;

  assign shx    = mag_q[3:2] - 2'd1;
  assign shy    = mag_q[1:0] - 2'd1;
  assign xpos   = {1'b0, xhi_q, xlo_q};
  assign ypos   = {1'b0, yhi_q, ylo_q};
  assign vpos10 = {1'b0, vpos_q};
  assign ylast  = ypos + (10'd16 << shy) - 10'd1;
  assign ydiff  = vpos10 - ypos;
  assign hit    = (mag_q[3:2] != 2'd0) && (mag_q[1:0] != 2'd0) &&
                  (vpos10 >= ypos) && (vpos10 <= ylast);
  assign sx     = 3'd1 << shx;
  assign pen_in = asic_ram_q[3:0];
  assign hpos10 = {1'b0, hpos};
  assign hidx   = hpos10[AW-1:0];
  assign rd_en  = pix_ce && (hpos10 < LW);

  // Each fetched pen is replicated across up to four columns in the same cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wcol[k] = xpos + (10'(dtag_q) << shx) + 10'(k);
      wen[k]  = (state_q == S_PAT) && dv_q && (pen_in != 4'd0) &&
                (3'(k) < sx) && (wcol[k] < LW);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (line_start) state_d = S_ATTR;
      S_ATTR:  if (cnt_q == 5'd5) state_d = S_CHECK;
      S_CHECK: state_d = hit ? S_PAT : S_NEXT;
      S_PAT:   if (cnt_q == 5'd16) state_d = S_NEXT;
      S_NEXT:  state_d = (idx_q == 4'd0) ? S_IDLE : S_ATTR;
      default: state_d = S_IDLE;
    endcase
    if (line_start) state_d = S_ATTR;
    if (!plus_mode) state_d = S_IDLE;
  end

  always_comb begin
    asic_ram_rd   = 1'b0;
    asic_ram_addr = 14'd0;
    busy          = (state_q != S_IDLE);
    unique case (state_q)
      S_ATTR: if (cnt_q < 5'd5) begin
        asic_ram_rd   = 1'b1;
        asic_ram_addr = ATTR_BASE + {7'd0, idx_q, 3'd0} + {9'd0, cnt_q};
      end
      S_PAT: if (cnt_q < 5'd16) begin
        asic_ram_rd   = 1'b1;
        asic_ram_addr = PAT_BASE + {2'd0, idx_q, row_q, cnt_q[3:0]};
      end
      default: ;
    endcase
  end

  // Read data returns one cycle after the strobe; dtag_q tells which byte it is.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      idx_q     <= 4'd0;
      cnt_q     <= 5'd0;
      dv_q      <= 1'b0;
      dtag_q    <= 4'd0;
      xlo_q     <= 8'd0;
      xhi_q     <= 1'b0;
      ylo_q     <= 8'd0;
      yhi_q     <= 1'b0;
      mag_q     <= 4'd0;
      row_q     <= 4'd0;
      vpos_q    <= 9'd0;
      sel_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dv_q      <= asic_ram_rd && !line_start && plus_mode;
      dtag_q    <= cnt_q[3:0];
      overrun_q <= line_start && busy;
      if (line_start || (state_d != state_q)) cnt_q <= 5'd0;
      else if (asic_ram_rd)                   cnt_q <= cnt_q + 5'd1;
      if (line_start) begin
        sel_q  <= ~sel_q;
        vpos_q <= next_vpos;
        idx_q  <= 4'd15;
      end else if (state_q == S_NEXT) begin
        idx_q <= idx_q - 4'd1;
      end
      if (state_q == S_ATTR && dv_q) begin
        unique case (dtag_q)
          4'd0:    xlo_q <= asic_ram_q;
          4'd1:    xhi_q <= asic_ram_q[0];
          4'd2:    ylo_q <= asic_ram_q;
          4'd3:    yhi_q <= asic_ram_q[0];
          default: mag_q <= asic_ram_q[3:0];
        endcase
      end
      if (state_q == S_CHECK) row_q <= 4'(ydiff >> shy);
    end
  end

  // The new fill buffer is wiped on every line_start; on overrun the partial fill is wiped too.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (wen[k]) vld_q[sel_q][wcol[k][AW-1:0]] <= 1'b1;
      if (rd_en) vld_q[~sel_q][hidx] <= 1'b0;
      if (line_start) begin
        vld_q[~sel_q] <= '0;
        if (busy) vld_q[sel_q] <= '0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int k = 0; k < 4; k++)
      if (wen[k]) ent_q[sel_q][wcol[k][AW-1:0]] <= {idx_q, pen_in};
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || !plus_mode) begin
      spr_valid_q <= 1'b0;
      spr_pen_q   <= 4'd0;
      spr_id_q    <= 4'd0;
    end else if (pix_ce) begin
      if (rd_en && vld_q[~sel_q][hidx]) begin
        spr_valid_q <= 1'b1;
        spr_id_q    <= ent_q[~sel_q][hidx][7:4];
        spr_pen_q   <= ent_q[~sel_q][hidx][3:0];
      end else begin
        spr_valid_q <= 1'b0;
        spr_pen_q   <= 4'd0;
        spr_id_q    <= 4'd0;
      end
    end
  end

  assign spr_valid = spr_valid_q;
  assign spr_pen   = spr_pen_q;
  assign spr_id    = spr_id_q;
  assign overrun   = overrun_q;

`ifdef GX4000_SPRITE_COLLIDE_EN
  logic [15:0] coll_q, coll_d;

  always_comb begin
    coll_d = coll_clr ? 16'd0 : coll_q;
    for (int k = 0; k < 4; k++) begin
      if (wen[k] && vld_q[sel_q][wcol[k][AW-1:0]]) begin
        coll_d[idx_q] = 1'b1;
        coll_d[ent_q[sel_q][wcol[k][AW-1:0]][7:4]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) coll_q <= 16'd0;
    else          coll_q <= coll_d;
  end

  assign collision_flags = coll_q;
`else
  logic unused_coll_clr;
  assign unused_coll_clr = coll_clr;
  assign collision_flags = 16'd0;
`endif

endmodule

// File: tb/tb_gx4000_sprite_linebuf.sv
// Scoreboard testbench for gx4000_sprite_linebuf; expected line contents come from a behavioural sprite model.
module tb_gx4000_sprite_linebuf;

  localparam int LW = 384;

  logic        clkSys = 1'b0;
  logic        resetN, plusMode, lineStart, pixCe, collClr;
  logic [8:0]  nextVpos, hposIn;
  logic [13:0] ramAddr;
  logic        ramRd;
  logic [7:0]  ramQ;
  logic        sprValid, busyO, overrunO;
  logic [3:0]  sprPen, sprId;
  logic [15:0] collFlags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [3:0] id;
    logic [3:0] pen;
  } pix_t;

  logic [7:0] mem [0:16383];
  pix_t       modelLine [LW];
  pix_t       sb [$];
  int         curVpos;
  bit         curEmpty;

  gx4000_sprite_linebuf dut (
    .clk_sys(clkSys), .reset_n(resetN), .plus_mode(plusMode), .line_start(lineStart),
    .next_vpos(nextVpos), .hpos(hposIn), .pix_ce(pixCe),
    .asic_ram_addr(ramAddr), .asic_ram_rd(ramRd), .asic_ram_q(ramQ),
    .spr_valid(sprValid), .spr_pen(sprPen), .spr_id(sprId),
    .busy(busyO), .overrun(overrunO), .coll_clr(collClr), .collision_flags(collFlags)
  );

  always #5 clkSys = ~clkSys;

  always @(posedge clkSys) if (ramRd) ramQ <= mem[ramAddr];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_sprite(int n, int x, int y, logic [3:0] mag);
    int ab;
    ab = 'h2000 + n * 8;
    mem[ab]     = 8'(x);
    mem[ab + 1] = 8'(x >> 8);
    mem[ab + 2] = 8'(y);
    mem[ab + 3] = 8'(y >> 8);
    mem[ab + 4] = {4'd0, mag};
  endtask

  task automatic clear_sprites();
    for (int n = 0; n < 16; n++) set_sprite(n, 0, 0, 4'd0);
  endtask

  // Column 15 of every row is transparent; the other pens rotate with row and offset.
  task automatic load_pattern(int n, int off);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[n * 256 + r * 16 + c] = (c == 15) ? 8'd0 : 8'(((r + c + off) % 15) + 1);
  endtask

  function automatic void build_model(int vpos);
    for (int i = 0; i < LW; i++) modelLine[i] = '0;
    for (int n = 15; n >= 0; n--) begin
      int ab, x, y, mx, my, sx, sy, r, col;
      logic [3:0] pen;
      ab = 'h2000 + n * 8;
      x  = {mem[ab + 1][0], mem[ab]};
      y  = {mem[ab + 3][0], mem[ab + 2]};
      mx = mem[ab + 4][3:2];
      my = mem[ab + 4][1:0];
      if (mx == 0 || my == 0) continue;
      sx = 1 << (mx - 1);
      sy = 1 << (my - 1);
      if (vpos < y || vpos > y + 16 * sy - 1) continue;
      r = (vpos - y) / sy;
      for (int c = 0; c < 16; c++) begin
        pen = mem[n * 256 + r * 16 + c][3:0];
        if (pen != 4'd0)
          for (int k = 0; k < sx; k++) begin
            col = x + c * sx + k;
            if (col < LW) modelLine[col] = {1'b1, 4'(n), pen};
          end
      end
    end
  endfunction

  task automatic pulse_line_start(int v);
    @(negedge clkSys);
    lineStart = 1'b1;
    nextVpos  = 9'(v);
    @(negedge clkSys);
    lineStart = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busyO && n < 1400) begin
      @(negedge clkSys);
      n++;
    end
    checks++;
    if (busyO !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s fill time: busy=%b after %0d cycles, required 0", name, busyO, n);
    end
  endtask

  task automatic fetch(int v);
    pulse_line_start(v);
    wait_idle("fetch");
    curVpos  = v;
    curEmpty = 0;
  endtask

  // Displays the previously fetched line while the next one is fetched into the other buffer.
  task automatic show(int nextLine, string name);
    pix_t e;
    if (curEmpty) for (int i = 0; i < LW; i++) modelLine[i] = '0;
    else          build_model(curVpos);
    pulse_line_start(nextLine);
    for (int h = 0; h < 400; h++) begin
      hposIn = 9'(h);
      pixCe  = 1'b1;
      sb.push_back((h < LW) ? modelLine[h] : pix_t'(0));
      @(posedge clkSys);
      #1;
      e = sb.pop_front();
      checks++;
      if (sprValid !== e.v || (e.v && (sprId !== e.id || sprPen !== e.pen))) begin
        errors++;
        $display("[TB] FAIL %s col %0d: got v=%b id=%0d pen=%0d, required v=%b id=%0d pen=%0d",
                 name, h, sprValid, sprId, sprPen, e.v, e.id, e.pen);
      end
      @(negedge clkSys);
    end
    pixCe = 1'b0;
    wait_idle(name);
    curVpos  = nextLine;
    curEmpty = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clkSys);
    @(negedge clkSys);
    checks++;
    if ({busyO, ramRd, overrunO, sprValid} !== 4'b0000 || ramAddr !== 14'd0 ||
        sprPen !== 4'd0 || sprId !== 4'd0 || collFlags !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset outputs: busy=%b rd=%b ov=%b v=%b addr=%h pen=%h id=%h coll=%h, required all 0",
               busyO, ramRd, overrunO, sprValid, ramAddr, sprPen, sprId, collFlags);
    end
    resetN = 1'b1;
    curEmpty = 1;
  endtask

  task automatic test_basic();
    clear_sprites();
    load_pattern(3, 0);
    set_sprite(3, 10, 20, 4'b0101);
    fetch(20);
    show(300, "basic_x1");
  endtask

  task automatic test_mag4();
    set_sprite(3, 10, 20, 4'b1111);
    fetch(20);
    show(23, "mag4_l20");
    show(24, "mag4_l23");
    show(83, "mag4_l24");
    show(84, "mag4_l83");
    show(300, "mag4_l84");
  endtask

  task automatic test_priority();
    logic [15:0] expColl;
`ifdef GX4000_SPRITE_COLLIDE_EN
    expColl = 16'h0021;
`else
    expColl = 16'h0000;
`endif
    clear_sprites();
    load_pattern(0, 3);
    load_pattern(5, 7);
    set_sprite(0, 100, 20, 4'b0101);
    set_sprite(5, 100, 20, 4'b0101);
    fetch(20);
    checks++;
    if (collFlags !== expColl) begin
      errors++;
      $display("[TB] FAIL collision set: got %h, required %h", collFlags, expColl);
    end
    collClr = 1'b1;
    @(negedge clkSys);
    collClr = 1'b0;
    checks++;
    if (collFlags !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL collision clear: got %h, required 0000", collFlags);
    end
    show(300, "priority");
  endtask

  task automatic test_right_edge();
    clear_sprites();
    load_pattern(1, 0);
    set_sprite(1, 380, 50, 4'b0101);
    fetch(50);
    show(300, "right_edge");
  endtask

  task automatic test_back_to_back();
    int ovCount = 0;
    clear_sprites();
    load_pattern(3, 0);
    set_sprite(3, 10, 20, 4'b1111);
    pulse_line_start(20);
    repeat (48) begin
      @(negedge clkSys);
      ovCount += int'(overrunO);
    end
    lineStart = 1'b1;
    nextVpos  = 9'd20;
    @(negedge clkSys);
    lineStart = 1'b0;
    ovCount += int'(overrunO);
    repeat (3) begin
      @(negedge clkSys);
      ovCount += int'(overrunO);
    end
    checks++;
    if (ovCount != 1) begin
      errors++;
      $display("[TB] FAIL overrun pulses: got %0d, required 1", ovCount);
    end
    wait_idle("overrun_refetch");
    curVpos  = 20;
    curEmpty = 0;
    show(300, "after_overrun");
  endtask

  task automatic test_reset_mid_pat();
    bit found = 0;
    clear_sprites();
    load_pattern(3, 0);
    set_sprite(3, 10, 20, 4'b0101);
    pulse_line_start(20);
    for (int i = 0; i < 400 && !found; i++) begin
      if (ramRd && ramAddr < 14'h2000) found = 1;
      else @(negedge clkSys);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL pattern read seen: got 0, required 1");
    end
    resetN = 1'b0;
    @(posedge clkSys);
    #1;
    checks++;
    if (busyO !== 1'b0 || ramRd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset mid-pat: busy=%b rd=%b, required 0 0", busyO, ramRd);
    end
    @(negedge clkSys);
    resetN   = 1'b1;
    curEmpty = 1;
    show(300, "after_reset");
  endtask

  task automatic test_plus_off();
    plusMode = 1'b0;
    pulse_line_start(20);
    checks++;
    if (busyO !== 1'b0 || ramRd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL plus_mode off fetch: busy=%b rd=%b, required 0 0", busyO, ramRd);
    end
    hposIn = 9'd15;
    pixCe  = 1'b1;
    @(negedge clkSys);
    pixCe  = 1'b0;
    checks++;
    if (sprValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL plus_mode off valid: got %b, required 0", sprValid);
    end
    plusMode = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    resetN = 1'b0; plusMode = 1'b1; lineStart = 1'b0; pixCe = 1'b0; collClr = 1'b0;
    nextVpos = 9'd0; hposIn = 9'd0; curVpos = 0; curEmpty = 1;
    test_reset();
    test_basic();
    test_mag4();
    test_priority();
    test_right_edge();
    test_back_to_back();
    test_reset_mid_pat();
    test_plus_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gx4000_sprite_linebuf.md
GX4000_SPRITE_LINEBUF -- requirements
Module: gx4000_sprite_linebuf

Interface
REQ-001 SHALL have parameter LINE_W, default 384, meaning visible pixels per line stored in each line buffer.
REQ-002 SHALL have parameter PAT_BASE, default 14'h0000, meaning the ASIC RAM base of the pattern area; sprite n pixel (r,c) is at PAT_BASE + n*256 + r*16 + c, with the pen in the low nibble.
REQ-003 SHALL have parameter ATTR_BASE, default 14'h2000, meaning the ASIC RAM base of the attribute area; sprite n bytes at ATTR_BASE + n*8 + {0:Xlo, 1:Xhi, 2:Ylo, 3:Yhi, 4:MAG}.
REQ-004 SHALL have port clk_sys, input, 1, the single clock.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port plus_mode, input, 1; when 0 the fetch engine stays IDLE and spr_valid is held 0.
REQ-007 SHALL have port line_start, input, 1, a one-cycle pulse that starts the fetch for the next line.
REQ-008 SHALL have port next_vpos, input, 9, the line to fetch, sampled on line_start.
REQ-009 SHALL have port hpos, input, 9, the current display pixel column.
REQ-010 SHALL have port pix_ce, input, 1, the pixel strobe.
REQ-011 SHALL have port asic_ram_addr, output, 14, the ASIC RAM read address.
REQ-012 SHALL have port asic_ram_rd, output, 1, the ASIC RAM read strobe.
REQ-013 SHALL have port asic_ram_q, input, 8, read data, valid exactly 1 cycle after asic_ram_rd.
REQ-014 SHALL have port spr_valid, output, 1, high when a non-transparent sprite pixel is at hpos.
REQ-015 SHALL have port spr_pen, output, 4, the sprite pen (1..15).
REQ-016 SHALL have port spr_id, output, 4, the index of the winning sprite.
REQ-017 SHALL have port busy, output, 1, high while the fetch engine is not IDLE.
REQ-018 SHALL have port overrun, output, 1, a one-cycle pulse when line_start arrives while busy.
REQ-019 SHALL have port coll_clr, input, 1, which clears collision_flags.
REQ-020 SHALL have port collision_flags, output, 16, sticky per-sprite collision bits.

Function
REQ-021 SHALL hold two line buffers (LINE_W x {valid, id[3:0], pen[3:0]}) used ping-pong; the buffer select toggles on each line_start.
REQ-022 SHALL, on pix_ce with hpos < LINE_W, read the display buffer at hpos, register it to spr_valid/spr_pen/spr_id 1 cycle later, and clear that entry in the same cycle.
REQ-023 SHALL drive spr_valid=0 on pix_ce with hpos >= LINE_W; outputs SHALL hold between pix_ce strobes.
REQ-024 SHALL implement fetch FSM states IDLE -> ATTR -> CHECK -> PAT -> NEXT -> (ATTR or IDLE); line_start moves IDLE->ATTR with sprite index 15.
REQ-025 In ATTR, SHALL read the 5 attribute bytes; X = {Xhi[0], Xlo}, Y = {Yhi[0], Ylo}, mag_x = MAG[3:2], mag_y = MAG[1:0], each coded 0=off, 1=x1, 2=x2, 3=x4.
REQ-026 In CHECK, SHALL skip to NEXT if mag_x==0, mag_y==0, or next_vpos is outside [Y, Y+16*scale_y-1] using 10-bit arithmetic; otherwise row = (next_vpos-Y)>>log2(scale_y).
REQ-027 In PAT, SHALL read 16 pattern bytes of the row; each nonzero pen SHALL be written scale_x times at columns X+c*scale_x+k, and columns >= LINE_W SHALL be dropped.
REQ-028 Pen 0 SHALL be transparent and never written.
REQ-029 SHALL process sprites 15 down to 0 so a lower index overwrites a higher one (sprite 0 highest priority).
REQ-030 NEXT SHALL decrement the index; after sprite 0 it SHALL return to IDLE.
REQ-031 asic_ram_rd SHALL be high only for FSM-issued reads, at most one outstanding.
REQ-032 On line_start while busy, SHALL pulse overrun, toggle the buffers, and restart at ATTR for sprite 15; the partial fill is discarded.
REQ-033 The worst-case fill (16 sprites at x4) SHALL complete within 1400 cycles.
REQ-034 If plus_mode falls mid-fetch, SHALL return to IDLE next cycle.

Reset
REQ-035 While reset_n==0 at a clk_sys edge: FSM IDLE, buffer select 0, spr_valid/spr_pen/spr_id/busy/overrun/asic_ram_rd 0, asic_ram_addr 0, collision_flags 0; buffer contents SHALL be treated as invalid (cleared by a reset sweep or valid-bit reset).

Configuration
REQ-036 With GX4000_SPRITE_COLLIDE_EN defined, a nonzero-pen write onto a valid entry SHALL set collision_flags bits of both the writing and the stored id; coll_clr SHALL zero the flags, and a set in the same cycle SHALL win.
REQ-037 Without GX4000_SPRITE_COLLIDE_EN, collision_flags SHALL be constant 0 and coll_clr ignored.

Verification
REQ-038 Sprite 3 at X=10, Y=20, MAG=4'b0101, row 0 = pens 1..15,0; line_start with next_vpos=20 -> next line columns 10..24 give pens 1..15 with id 3, and column 25 gives spr_valid=0.
REQ-039 Same sprite with MAG=4'b1111 -> each pen spans 4 columns (10..69), and lines 20..83 show rows 0..15 each repeated 4x.
REQ-040 Sprites 0 and 5 both at X=100 -> id 0 shown; with COLLIDE_EN, collision_flags=16'h0021, and coll_clr -> 0.
REQ-041 X=380, x1 -> only columns 380..383 written; no write beyond LINE_W.
REQ-042 line_start, then a second line_start after 50 cycles -> overrun pulses once, fetch restarts, and the displayed line has no stale pixels.
REQ-043 reset_n low mid-PAT -> next cycle busy=0, asic_ram_rd=0, and next displayed line empty.
